// File: rtl/mul16_seq.sv
// Unsigned 16x16->32 shift-and-add multiplier that uses one prefix adder iteratively.
// Latency: start accepted at E0, done and p valid after E16 (17 cycles start-to-done).
// Backpressure: start is ignored while busy; a start in the DONE cycle chains the next operation.
module mul16_seq (
    input  logic        clk,
    input  logic        rstN,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] p
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] m_r, m_nxt;
    logic [15:0] a_r, a_nxt;
    logic [15:0] q_r, q_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic [31:0] p_r, p_nxt;

    logic [15:0] sum;
    logic        c_out;
    logic [31:0] shifted;

    Prefix_Add16 u_add (
        .x    (a_r),
        .y    (q_r[0] ? m_r : 16'h0000),
        .cIn  (1'b0),
        .s    (sum),
        .cOut (c_out)
    );

    // Carry lands in the top accumulator bit; Q[0] has been consumed and drops off.
    assign shifted = {c_out, sum, q_r[15:1]};

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= S_IDLE;
            m_r   <= '0;
            a_r   <= '0;
            q_r   <= '0;
            cnt   <= '0;
            p_r   <= '0;
        end else begin
            state <= state_nxt;
            m_r   <= m_nxt;
            a_r   <= a_nxt;
            q_r   <= q_nxt;
            cnt   <= cnt_nxt;
            p_r   <= p_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        m_nxt     = m_r;
        a_nxt     = a_r;
        q_nxt     = q_r;
        cnt_nxt   = cnt;
        p_nxt     = p_r;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    m_nxt     = a;
                    q_nxt     = b;
                    a_nxt     = '0;
                    cnt_nxt   = '0;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                {a_nxt, q_nxt} = shifted;
                cnt_nxt        = cnt + 5'd1;
                if (cnt == 5'd15) begin
                    p_nxt     = shifted;
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);
    assign p    = p_r;
endmodule

// 16-bit Kogge-Stone prefix adder with carry-in folded into bit 0's generate.
// Purely combinational; no backpressure.
module Prefix_Add16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        cIn,
    output logic [15:0] s,
    output logic        cOut
);
    logic [15:0] hp;
    logic [15:0] gl [0:4];
    logic [15:0] pl [0:3];

    assign hp    = x ^ y;
    assign pl[0] = hp;
    assign gl[0] = {x[15:1] & y[15:1], (x[0] & y[0]) | (hp[0] & cIn)};

    genvar l, i;
    for (l = 1; l <= 4; l++) begin : g_lvl
        localparam int D = 1 << (l - 1);
        for (i = 0; i < 16; i++) begin : g_bit
            if (i >= D) begin : g_comb
                assign gl[l][i] = gl[l-1][i] | (pl[l-1][i] & gl[l-1][i-D]);
                if (l < 4) begin : g_p
                    assign pl[l][i] = pl[l-1][i] & pl[l-1][i-D];
                end
            end else begin : g_pass
                assign gl[l][i] = gl[l-1][i];
                if (l < 4) begin : g_p
                    assign pl[l][i] = pl[l-1][i];
                end
            end
        end
    end

    // gl[4][i] is the carry out of bit i.
    assign s    = hp ^ {gl[4][14:0], cIn};
    assign cOut = gl[4][15];
endmodule

// File: tb/tb_mul16_seq.sv
// Bench for mul16_seq: directed handshake scenarios plus random operands against a*b.
module tb_mul16_seq;
    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] p;

    int checks = 0;
    int errors = 0;

    mul16_seq dut (
        .clk   (clk),
        .rstN  (rstN),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
        return 32'(x) * 32'(y);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation and waits (bounded) for done; observations are after each edge.
    task automatic do_op(input logic [15:0] xa, input logic [15:0] xb,
                         output int busy_cnt, output int lat, output logic [31:0] pv,
                         output logic got_done);
        a = xa; b = xb; start = 1'b1;
        tick();
        start = 1'b0;
        busy_cnt = 0; lat = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            lat++;
            tick();
        end
        got_done = done;
        pv = p;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        tick(); tick();
        checks++;
        if ({busy, done, p} !== 34'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b p=%h, expected 0 0 00000000", busy, done, p);
        end
        #2 rstN = 1'b1;
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int bc, lat; logic [31:0] pv; logic gd;
        do_op(16'h0003, 16'h0005, bc, lat, pv, gd);
        checks++;
        if (!gd) begin errors++; $display("FAIL basic_timeout: no done within 40 cycles"); end
        checks++;
        if (bc !== 16) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 16", bc); end
        checks++;
        if (lat !== 16) begin errors++; $display("FAIL basic_latency: got %0d expected 16", lat); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done: got %b expected 0", busy); end
        checks++;
        if (pv !== 32'h0000000F) begin errors++; $display("FAIL basic_product: got %h expected 0000000f", pv); end
        tick();
        checks++;
        if (done !== 1'b0 || p !== 32'h0000000F) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b p=%h, expected 0 0000000f", done, p);
        end
    endtask

    task automatic test_max_and_hold();
        int bc, lat, n; logic [31:0] pv; logic gd; logic held;
        do_op(16'hFFFF, 16'hFFFF, bc, lat, pv, gd);
        checks++;
        if (!gd || pv !== 32'hFFFE0001) begin
            errors++; $display("FAIL max_product: got %h done=%b expected fffe0001", pv, gd);
        end
        tick();
        do_op(16'h1234, 16'h5678, bc, lat, pv, gd);
        checks++;
        if (!gd || pv !== 32'h06260060) begin
            errors++; $display("FAIL product_1234x5678: got %h expected 06260060", pv);
        end
        tick(); tick();
        a = 16'h0000; b = 16'hBEEF; start = 1'b1;
        tick();
        start = 1'b0;
        held = 1'b1; n = 0;
        while (!done && n < 40) begin
            if (p !== 32'h06260060) held = 1'b0;
            n++;
            tick();
        end
        checks++;
        if (!held) begin errors++; $display("FAIL p_hold_during_op: p changed before done, expected 06260060"); end
        checks++;
        if (!done || p !== 32'h00000000 || n !== 16) begin
            errors++; $display("FAIL zero_product: p=%h lat=%0d expected 00000000 lat 16", p, n);
        end
        tick();
    endtask

    task automatic test_ignore_start();
        int pulses, first_at;
        a = 16'h0002; b = 16'h0003; start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0; first_at = -1;
        for (int k = 0; k < 30; k++) begin
            if (done) begin
                pulses++;
                if (first_at < 0) begin
                    first_at = k;
                    checks++;
                    if (p !== 32'h00000006) begin
                        errors++; $display("FAIL ignore_start_product: got %h expected 00000006", p);
                    end
                end
            end
            if (k == 4) begin a = 16'hFFFF; b = 16'hFFFF; start = 1'b1; end
            else start = 1'b0;
            tick();
        end
        checks++;
        if (pulses !== 1 || first_at !== 16) begin
            errors++; $display("FAIL ignore_start_done: pulses=%0d at=%0d expected 1 at 16", pulses, first_at);
        end
    endtask

    task automatic test_back_to_back();
        int dn; int at [2]; logic [31:0] pr [2]; logic busy_ok;
        a = 16'h0010; b = 16'h0010; start = 1'b1;
        tick();
        dn = 0; busy_ok = 1'b1; at[0] = -1; at[1] = -1; pr[0] = '0; pr[1] = '0;
        for (int k = 0; k < 34; k++) begin
            if (busy !== !done) busy_ok = 1'b0;
            if (done && dn < 2) begin
                at[dn] = k; pr[dn] = p; dn++;
                a = 16'h0100; b = 16'h0100;
                if (dn == 2) start = 1'b0;
            end
            if (k < 33) tick();
        end
        start = 1'b0;
        checks++;
        if (at[0] !== 16 || at[1] !== 33) begin
            errors++; $display("FAIL b2b_done_spacing: at %0d,%0d expected 16,33", at[0], at[1]);
        end
        checks++;
        if (pr[0] !== 32'h00000100 || pr[1] !== 32'h00010000) begin
            errors++; $display("FAIL b2b_products: got %h,%h expected 00000100,00010000", pr[0], pr[1]);
        end
        checks++;
        if (!busy_ok) begin errors++; $display("FAIL b2b_busy: busy not equal to !done in some cycle"); end
        tick(); tick();
    endtask

    task automatic test_reset_midrun();
        int bc, lat, seen; logic [31:0] pv; logic gd;
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        #2 rstN = 1'b0;
        #1;
        checks++;
        if ({busy, done, p} !== 34'd0) begin
            errors++; $display("FAIL async_reset: busy=%b done=%b p=%h expected 0 0 00000000", busy, done, p);
        end
        tick();
        #2 rstN = 1'b1;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL reset_abandon: %0d busy/done cycles, expected 0", seen); end
        do_op(16'h0007, 16'h0009, bc, lat, pv, gd);
        checks++;
        if (!gd || pv !== 32'h0000003F || lat !== 16) begin
            errors++; $display("FAIL post_reset_op: p=%h lat=%0d expected 0000003f lat 16", pv, lat);
        end
        tick();
    endtask

    task automatic test_random();
        int bc, lat; logic [31:0] pv; logic gd; logic [15:0] x, y;
        for (int n = 0; n < 24; n++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            if (n % 6 == 0) x = 16'hFFFF;
            if (n % 8 == 1) y = 16'h8001;
            do_op(x, y, bc, lat, pv, gd);
            checks++;
            if (!gd || pv !== model(x, y) || lat !== 16) begin
                errors++;
                $display("FAIL random_%0d %h*%h: got %h lat %0d expected %h lat 16", n, x, y, pv, lat, model(x, y));
            end
            if (n % 3 == 0) tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_and_hold();
        test_ignore_start();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
